// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM generator and the PWM capture block.
package pwm_pkg;
  localparam int PWM_CLK_FREQ = 12_000_000;

  typedef enum logic [1:0] {CAP_IDLE, CAP_ARM, CAP_MEAS} cap_state_t;
endpackage

// File: rtl/bit_sync_edge.sv
// Multi-flop synchronizer for an asynchronous level, with rise/fall strobes
// derived from the synchronized value (strobes are combinational, one cycle wide).
module bit_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_q,
  output logic o_rise,
  output logic o_fall
);
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_d};
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  assign o_q    = r_sync[SYNC_STAGES-1];
  assign o_rise = o_q & ~r_prev;
  assign o_fall = ~o_q & r_prev;
endmodule

// File: rtl/pwm_capture.sv
// Measures period and high time of an asynchronous pulse input in clk cycles, and flags a
// stuck input when no rising edge arrives within TIMEOUT_CYCLES of the previous one.
module pwm_capture
  import pwm_pkg::*;
#(
  parameter int  CLK_FREQ       = PWM_CLK_FREQ,
  parameter int  SYNC_STAGES    = 2,
  parameter int  TIMEOUT_CYCLES = 1200000,
  localparam int CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_pwm,
  input  logic             i_enable,
  output logic [CNT_W-1:0] o_period,
  output logic [CNT_W-1:0] o_high,
  output logic             o_valid,
  output logic             o_stuck,
  output logic             o_level,
  output logic             o_busy
);
  if (SYNC_STAGES < 2 || CLK_FREQ < 1) begin : g_bad_param
    $error("pwm_capture: SYNC_STAGES must be >= 2 and CLK_FREQ positive");
  end

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  cap_state_t       r_state, w_state_nxt;
  logic [CNT_W-1:0] r_per_cnt, r_hi_cnt, r_period, r_high;
  logic [CNT_W-1:0] w_per_nxt, w_hi_nxt, w_period_nxt, w_high_nxt;
  logic             r_valid, r_stuck, r_level;
  logic             w_valid_nxt, w_stuck_nxt, w_level_nxt;
  logic             w_s, w_rise, w_fall;

  bit_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk    (clk),
    .rst    (rst),
    .i_d    (i_pwm),
    .o_q    (w_s),
    .o_rise (w_rise),
    .o_fall (w_fall)
  );

  always_comb begin
    w_state_nxt  = r_state;
    w_per_nxt    = r_per_cnt;
    w_hi_nxt     = r_hi_cnt;
    w_period_nxt = r_period;
    w_high_nxt   = r_high;
    w_valid_nxt  = 1'b0;
    w_stuck_nxt  = r_stuck;
    w_level_nxt  = r_level;
    if (!i_enable) begin
      // Abort takes priority over an edge arriving in the same cycle.
      w_state_nxt = CAP_IDLE;
      w_per_nxt   = '0;
      w_hi_nxt    = '0;
    end else begin
      case (r_state)
        CAP_IDLE: w_state_nxt = CAP_ARM;
        CAP_ARM: begin
          if (w_rise) begin
            w_state_nxt = CAP_MEAS;
            w_per_nxt   = CNT_ONE;
            w_hi_nxt    = CNT_ONE;
          end
        end
        CAP_MEAS: begin
          if (w_rise) begin
            w_period_nxt = r_per_cnt;
            w_high_nxt   = r_hi_cnt;
            w_valid_nxt  = 1'b1;
            w_stuck_nxt  = 1'b0;
            w_per_nxt    = CNT_ONE;
            w_hi_nxt     = CNT_ONE;
          end else if (r_per_cnt == CNT_LAST) begin
            // Window would reach TIMEOUT_CYCLES without an edge: input is dead.
            w_stuck_nxt = 1'b1;
            w_level_nxt = w_s;
            w_state_nxt = CAP_ARM;
            w_per_nxt   = '0;
            w_hi_nxt    = '0;
          end else begin
            w_per_nxt = r_per_cnt + CNT_ONE;
            w_hi_nxt  = r_hi_cnt + CNT_W'(w_s);
          end
        end
        default: w_state_nxt = CAP_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= CAP_IDLE;
      r_per_cnt <= '0;
      r_hi_cnt  <= '0;
      r_period  <= '0;
      r_high    <= '0;
      r_valid   <= 1'b0;
      r_stuck   <= 1'b0;
      r_level   <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_per_cnt <= w_per_nxt;
      r_hi_cnt  <= w_hi_nxt;
      r_period  <= w_period_nxt;
      r_high    <= w_high_nxt;
      r_valid   <= w_valid_nxt;
      r_stuck   <= w_stuck_nxt;
      r_level   <= w_level_nxt;
    end
  end

  assign o_period = r_period;
  assign o_high   = r_high;
  assign o_valid  = r_valid;
  assign o_stuck  = r_stuck;
  assign o_level  = r_level;
  assign o_busy   = (r_state == CAP_MEAS);

  a_edges_exclusive : assert property (@(posedge clk) disable iff (rst) !(w_rise && w_fall));
  a_meas_bounds : assert property (@(posedge clk) disable iff (rst)
    r_valid |-> (r_high != '0) && (r_high <= r_period) && (r_period <= CNT_LAST));
endmodule
